trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
//  Sequences every privileged control transfer (synchronous exception, machine interrupt, MRET) around the csr block.
//  Arbitrates simultaneous sources, flushes and drains the pipeline, then pulses the csr trap/mret update.
//  Finally redirects fetch to the handler vector or to mepc.
//  Sits between the decode/execute exception logic, the interrupt lines, csr and the fetch PC mux.
// PARAMETERS
//  VECTORED_EN  1   1: honour mtvec[1:0]==01 vectored mode for interrupts; 0: always direct mode.
//  DRAIN_MAX    15  max cycles waiting for pipe_empty before forcing commit (0 = wait forever).
// PORTS
//  clk             in   1   core clock; all state changes on rising edge.
//  reset           in   1   asynchronous, active-high reset.
//  exc_valid       in   1   synchronous exception raised by the oldest instruction.
//  exc_cause       in   32  mcause code for exc_valid (bit31=0).
//  exc_pc          in   32  PC of the faulting instruction.
//  mret_valid      in   1   MRET reached commit.
//  irq_ext/irq_sw/irq_tmr in 1 each  level interrupt lines (mip bits 11/3/7).
//  mie_bits        in   32  csr mie register.
//  mstatus_mie     in   1   csr mstatus.MIE.
//  mtvec           in   32  csr mtvec.
//  mepc            in   32  csr mepc (MRET target).
//  current_pc      in   32  PC of the next instruction to retire (interrupt return point).
//  pipe_empty      in   1   no instruction in flight past fetch.
//  redirect_ready  in   1   fetch accepted redirect_pc this cycle.
//  flush           out  1   kill all in-flight instructions.
//  stall_fetch     out  1   hold fetch; high whenever state!=IDLE.
//  csr_trap_we     out  1   one-cycle pulse: csr writes mepc/mcause/mstatus trap update.
//  csr_mret_we     out  1   one-cycle pulse: csr performs mstatus MRET restore.
//  trap_cause      out  32  latched mcause value.
//  trap_pc         out  32  latched mepc value.
//  redirect_valid  out  1   redirect_pc valid; held until redirect_ready.
//  redirect_pc     out  32  handler address or mepc.
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; trap_cause/trap_pc/redirect_pc cleared to 0.
//  States: IDLE -> DRAIN -> COMMIT -> REDIRECT -> IDLE.
//  Interrupt pending: irq_p = mstatus_mie & |({irq_ext,irq_sw,irq_tmr} & mie_bits{11,3,7}).
//  Priority in IDLE: exc_valid > mret_valid > irq_p; within irq_p: ext > sw > tmr.
//  IDLE, event at edge T: latch kind, cause and pc; enter DRAIN.
//   exc: cause=exc_cause, pc=exc_pc. mret: pc=mepc.
//   irq: cause=0x8000000B / 0x80000003 / 0x80000007, pc=current_pc.
//  DRAIN: flush=1, stall_fetch=1. Leave to COMMIT on pipe_empty, or after DRAIN_MAX cycles if DRAIN_MAX!=0.
//   Minimum 1 DRAIN cycle: with pipe_empty=1, csr pulse is at T+2.
//  COMMIT: exactly one cycle; csr_trap_we=1 (exc/irq) or csr_mret_we=1 (mret). Compute redirect_pc:
//   mret: latched mepc.
//   exc: {mtvec[31:2],2'b00}.
//   irq with VECTORED_EN & mtvec[1:0]==01: {mtvec[31:2],2'b00} + 4*cause[4:0] (32-bit add, wrap ignored).
//   otherwise: base.
//  REDIRECT: redirect_valid=1, stall_fetch=1, redirect_pc stable; IDLE on edge with redirect_ready=1.
//  While state!=IDLE all new exc/mret/irq inputs are ignored, not queued.
//   Exceptions die with the flush; irq is level and resampled in IDLE.
//   After a trap, csr clears MIE, so the same irq is not retaken.
//  A simultaneous exc and irq takes the exception; the irq is retaken later only if MIE is still set.
//  Reset asserted mid-sequence returns to IDLE immediately; no csr pulse or redirect completes.
//  mie_bits/mtvec changes after latching do not alter cause; mtvec is read in COMMIT.
// TESTING
//  1) exc_valid with cause=2, exc_pc=0x100, mtvec=0x2000, pipe_empty=1:
//     flush at T+1, csr_trap_we at T+2 with trap_cause=2 and trap_pc=0x100, redirect_pc=0x2000.
//  2) irq_tmr=1, mie[7]=1, MIE=1, mtvec=0x2001, current_pc=0x40: trap_cause=0x80000007, redirect_pc=0x201C.
//     Same stimulus with VECTORED_EN=0: redirect_pc=0x2000.
//  3) irq_ext+irq_sw+exc_valid in the same cycle: exception taken first.
//     With MIE kept at 1 the next sequence has cause 0x8000000B.
//  4) mret_valid with mepc=0x344: csr_mret_we is the only pulse, redirect_pc=0x344.
//     With redirect_ready low 3 cycles, redirect_valid and redirect_pc stay stable.
//  5) pipe_empty held 0 with DRAIN_MAX=15: COMMIT is forced after 15 DRAIN cycles.
//     Reset during DRAIN: all outputs are 0 the next cycle.
//  6) irq with mstatus_mie=0 or the mie bit clear: state stays IDLE, no flush.

Source files
------------

// File: rtl/trap_sequencer.sv
// ============================================================================
// Module   : trap_sequencer
// Purpose  : Sequences every privileged control transfer (synchronous
//            exception, machine interrupt, MRET) around the csr block.
//            A taken event is latched in IDLE, the pipeline is flushed and
//            drained, the csr trap/mret update is pulsed for one cycle, and
//            fetch is redirected to the handler vector or to mepc.
// Ports    :
//   clk_i            core clock, rising edge
//   reset_i          asynchronous active-high reset
//   exc_valid_i      synchronous exception from the oldest instruction
//   exc_cause_i      mcause for the exception
//   exc_pc_i         PC of the faulting instruction
//   mret_valid_i     MRET reached commit
//   irq_ext_i/irq_sw_i/irq_tmr_i  level interrupt lines (mip 11/3/7)
//   mie_bits_i       csr mie
//   mstatus_mie_i    csr mstatus.MIE
//   mtvec_i          csr mtvec (sampled while committing)
//   mepc_i           csr mepc (MRET target)
//   current_pc_i     interrupt return point
//   pipe_empty_i     no instruction in flight past fetch
//   redirect_ready_i fetch accepted redirect_pc_o
//   flush_o          kill in-flight instructions (DRAIN)
//   stall_fetch_o    hold fetch while not IDLE
//   csr_trap_we_o    one-cycle trap update pulse
//   csr_mret_we_o    one-cycle MRET restore pulse
//   trap_cause_o     latched mcause
//   trap_pc_o        latched mepc value
//   redirect_valid_o redirect_pc_o valid, held until accepted
//   redirect_pc_o    handler address or mepc
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_sequencer #(
    parameter bit VECTORED_EN = 1'b1,
    parameter int DRAIN_MAX   = 15
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        exc_valid_i,
    input  logic [31:0] exc_cause_i,
    input  logic [31:0] exc_pc_i,
    input  logic        mret_valid_i,
    input  logic        irq_ext_i,
    input  logic        irq_sw_i,
    input  logic        irq_tmr_i,
    input  logic [31:0] mie_bits_i,
    input  logic        mstatus_mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic [31:0] current_pc_i,
    input  logic        pipe_empty_i,
    input  logic        redirect_ready_i,
    output logic        flush_o,
    output logic        stall_fetch_o,
    output logic        csr_trap_we_o,
    output logic        csr_mret_we_o,
    output logic [31:0] trap_cause_o,
    output logic [31:0] trap_pc_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAIN    = 2'd1,
        S_COMMIT   = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        K_EXC  = 2'd0,
        K_MRET = 2'd1,
        K_IRQ  = 2'd2
    } kind_t;

    // Drain counter counts 0 .. DRAIN_MAX-1; the last value forces COMMIT.
    localparam int CNT_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST =
        (DRAIN_MAX > 0) ? CNT_W'(DRAIN_MAX - 1) : '0;

    localparam logic [31:0] c_CAUSE_EXT = 32'h8000_000B;
    localparam logic [31:0] c_CAUSE_SW  = 32'h8000_0003;
    localparam logic [31:0] c_CAUSE_TMR = 32'h8000_0007;

    state_t             state_q;
    kind_t              kind_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               flush_q;
    logic               stall_q;
    logic               trap_we_q;
    logic               mret_we_q;
    logic [31:0]        cause_q;
    logic [31:0]        pc_q;
    logic               rvalid_q;
    logic [31:0]        rpc_q;

    // ------------------------------------------------------------------
    // Interrupt qualification and fixed priority ext > sw > tmr
    // ------------------------------------------------------------------
    logic        w_ext_en;
    logic        w_sw_en;
    logic        w_tmr_en;
    logic        w_irq_pending;
    logic [31:0] w_irq_cause;
    logic        w_event;
    logic        w_drain_done;

    assign w_ext_en      = irq_ext_i & mie_bits_i[11];
    assign w_sw_en       = irq_sw_i  & mie_bits_i[3];
    assign w_tmr_en      = irq_tmr_i & mie_bits_i[7];
    assign w_irq_pending = mstatus_mie_i & (w_ext_en | w_sw_en | w_tmr_en);

    always_comb begin
        w_irq_cause = c_CAUSE_TMR;
        if (w_ext_en) begin
            w_irq_cause = c_CAUSE_EXT;
        end else if (w_sw_en) begin
            w_irq_cause = c_CAUSE_SW;
        end
    end

    assign w_event = exc_valid_i | mret_valid_i | w_irq_pending;

    // DRAIN ends on an empty pipe, or on timeout when a limit is configured.
    assign w_drain_done = pipe_empty_i |
                          ((DRAIN_MAX != 0) && (cnt_q == c_CNT_LAST));

    // Only the interrupt-relevant mie bits are consumed.
    logic w_unused;
    assign w_unused = &{1'b0, mie_bits_i[31:12], mie_bits_i[10:8],
                        mie_bits_i[6:4], mie_bits_i[2:0]};

    // ------------------------------------------------------------------
    // Redirect target. Vectored mode applies to interrupts only; the
    // offset is 4*cause[4:0] added to the aligned base, wrap ignored.
    // ------------------------------------------------------------------
    function automatic logic [31:0] f_target(
        input kind_t       kind,
        input logic [4:0]  cause_lo,
        input logic [31:0] pc,
        input logic [31:0] tvec
    );
        logic [31:0] base;
        base = {tvec[31:2], 2'b00};
        if (kind == K_MRET) begin
            return pc;
        end
        if ((kind == K_IRQ) && VECTORED_EN && (tvec[1:0] == 2'b01)) begin
            return base + {25'd0, cause_lo, 2'b00};
        end
        return base;
    endfunction

    // ------------------------------------------------------------------
    // Sequencer with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            kind_q    <= K_EXC;
            cnt_q     <= '0;
            flush_q   <= 1'b0;
            stall_q   <= 1'b0;
            trap_we_q <= 1'b0;
            mret_we_q <= 1'b0;
            cause_q   <= 32'd0;
            pc_q      <= 32'd0;
            rvalid_q  <= 1'b0;
            rpc_q     <= 32'd0;
        end else begin
            // csr pulses are single-cycle by construction
            trap_we_q <= 1'b0;
            mret_we_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (exc_valid_i) begin
                        kind_q  <= K_EXC;
                        cause_q <= exc_cause_i;
                        pc_q    <= exc_pc_i;
                    end else if (mret_valid_i) begin
                        // mcause is left untouched by MRET
                        kind_q  <= K_MRET;
                        pc_q    <= mepc_i;
                    end else if (w_irq_pending) begin
                        kind_q  <= K_IRQ;
                        cause_q <= w_irq_cause;
                        pc_q    <= current_pc_i;
                    end
                    if (w_event) begin
                        state_q <= S_DRAIN;
                        flush_q <= 1'b1;
                        stall_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                end

                S_DRAIN: begin
                    if (w_drain_done) begin
                        state_q <= S_COMMIT;
                        flush_q <= 1'b0;
                        if (kind_q == K_MRET) begin
                            mret_we_q <= 1'b1;
                        end else begin
                            trap_we_q <= 1'b1;
                        end
                        // Early copy so the target is visible alongside the
                        // csr pulse; it is refreshed from mtvec in COMMIT.
                        rpc_q <= f_target(kind_q, cause_q[4:0], pc_q, mtvec_i);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_COMMIT: begin
                    state_q  <= S_REDIRECT;
                    rvalid_q <= 1'b1;
                    rpc_q    <= f_target(kind_q, cause_q[4:0], pc_q, mtvec_i);
                end

                S_REDIRECT: begin
                    if (redirect_ready_i) begin
                        state_q  <= S_IDLE;
                        rvalid_q <= 1'b0;
                        stall_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q  <= S_IDLE;
                    flush_q  <= 1'b0;
                    stall_q  <= 1'b0;
                    rvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign flush_o          = flush_q;
    assign stall_fetch_o    = stall_q;
    assign csr_trap_we_o    = trap_we_q;
    assign csr_mret_we_o    = mret_we_q;
    assign trap_cause_o     = cause_q;
    assign trap_pc_o        = pc_q;
    assign redirect_valid_o = rvalid_q;
    assign redirect_pc_o    = rpc_q;

endmodule

`default_nettype wire

// File: tb/tb_trap_sequencer.sv
// ============================================================================
// Module   : tb_trap_sequencer
// Purpose  : Directed self-checking bench for trap_sequencer. Expected
//            transfers are queued when an event is driven and popped when
//            the csr pulse appears. A second instance runs in direct mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_sequencer;

    logic        clk;
    logic        reset_i;
    logic        exc_valid_i;
    logic [31:0] exc_cause_i;
    logic [31:0] exc_pc_i;
    logic        mret_valid_i;
    logic        irq_ext_i;
    logic        irq_sw_i;
    logic        irq_tmr_i;
    logic [31:0] mie_bits_i;
    logic        mstatus_mie_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic [31:0] current_pc_i;
    logic        pipe_empty_i;
    logic        redirect_ready_i;

    logic        flush_o, stall_fetch_o, csr_trap_we_o, csr_mret_we_o;
    logic [31:0] trap_cause_o, trap_pc_o, redirect_pc_o;
    logic        redirect_valid_o;

    logic        flush_nv, stall_nv, trap_we_nv, mret_we_nv, rvalid_nv;
    logic [31:0] cause_nv, pc_nv, rpc_nv;

    trap_sequencer #(.VECTORED_EN(1'b1), .DRAIN_MAX(15)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
        .mret_valid_i(mret_valid_i),
        .irq_ext_i(irq_ext_i), .irq_sw_i(irq_sw_i), .irq_tmr_i(irq_tmr_i),
        .mie_bits_i(mie_bits_i), .mstatus_mie_i(mstatus_mie_i),
        .mtvec_i(mtvec_i), .mepc_i(mepc_i), .current_pc_i(current_pc_i),
        .pipe_empty_i(pipe_empty_i), .redirect_ready_i(redirect_ready_i),
        .flush_o(flush_o), .stall_fetch_o(stall_fetch_o),
        .csr_trap_we_o(csr_trap_we_o), .csr_mret_we_o(csr_mret_we_o),
        .trap_cause_o(trap_cause_o), .trap_pc_o(trap_pc_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
    );

    trap_sequencer #(.VECTORED_EN(1'b0), .DRAIN_MAX(15)) dut_nv (
        .clk_i(clk), .reset_i(reset_i),
        .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
        .mret_valid_i(mret_valid_i),
        .irq_ext_i(irq_ext_i), .irq_sw_i(irq_sw_i), .irq_tmr_i(irq_tmr_i),
        .mie_bits_i(mie_bits_i), .mstatus_mie_i(mstatus_mie_i),
        .mtvec_i(mtvec_i), .mepc_i(mepc_i), .current_pc_i(current_pc_i),
        .pipe_empty_i(pipe_empty_i), .redirect_ready_i(redirect_ready_i),
        .flush_o(flush_nv), .stall_fetch_o(stall_nv),
        .csr_trap_we_o(trap_we_nv), .csr_mret_we_o(mret_we_nv),
        .trap_cause_o(cause_nv), .trap_pc_o(pc_nv),
        .redirect_valid_o(rvalid_nv), .redirect_pc_o(rpc_nv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          mret;
        logic [31:0] cause;
        logic [31:0] pc;
        logic [31:0] target;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit mret, input logic [31:0] cause,
                        input logic [31:0] pc, input logic [31:0] target);
        exp_t e;
        e.mret = mret; e.cause = cause; e.pc = pc; e.target = target;
        sbq.push_back(e);
    endtask

    // Let the event be sampled on the next rising edge, then drop the
    // single-shot requests (level irqs are handled by the caller).
    task automatic fire();
        @(negedge clk);
        exc_valid_i  = 1'b0;
        mret_valid_i = 1'b0;
    endtask

    // Called on the negedge right after the event edge. Follows the
    // sequence through DRAIN, COMMIT and REDIRECT and checks it against
    // the head of the scoreboard.
    task automatic run_seq(input string name, input int exp_drain, input int ready_delay);
        exp_t e;
        int   n;
        logic [31:0] keep_tvec;
        n = 0;
        while (!(csr_trap_we_o || csr_mret_we_o) && n < 64) begin
            chk({name, "_flush"}, 32'(flush_o), 32'd1);
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_cycles"}, 32'(n), 32'(exp_drain));
        n_cmp++;
        assert (sbq.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_scoreboard: observed empty queue expected entry", name);
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({name, "_trap_we"}, 32'(csr_trap_we_o), 32'(!e.mret));
            chk({name, "_mret_we"}, 32'(csr_mret_we_o), 32'(e.mret));
            chk({name, "_trap_pc"}, trap_pc_o, e.pc);
            if (!e.mret) chk({name, "_trap_cause"}, trap_cause_o, e.cause);
            chk({name, "_rpc_commit"}, redirect_pc_o, e.target);
            chk({name, "_stall_commit"}, 32'(stall_fetch_o), 32'd1);

            redirect_ready_i = (ready_delay == 0);
            @(negedge clk);
            chk({name, "_rvalid"}, 32'(redirect_valid_o), 32'd1);
            chk({name, "_rpc"}, redirect_pc_o, e.target);
            chk({name, "_pulse_off"}, 32'({csr_trap_we_o, csr_mret_we_o}), 32'd0);
            chk({name, "_stall_redir"}, 32'(stall_fetch_o), 32'd1);

            // redirect must stay stable while fetch withholds ready,
            // even if mtvec moves underneath it
            keep_tvec = mtvec_i;
            for (int i = 1; i < ready_delay; i++) begin
                mtvec_i = 32'h0000_9000 + 32'(i * 4);
                @(negedge clk);
                chk({name, "_hold_rvalid"}, 32'(redirect_valid_o), 32'd1);
                chk({name, "_hold_rpc"}, redirect_pc_o, e.target);
            end
            mtvec_i = keep_tvec;
            redirect_ready_i = 1'b1;
            @(negedge clk);
            chk({name, "_rvalid_off"}, 32'(redirect_valid_o), 32'd0);
            chk({name, "_stall_off"}, 32'(stall_fetch_o), 32'd0);
        end
    endtask

    task automatic check_quiet(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk({name, "_flush"}, 32'(flush_o), 32'd0);
            chk({name, "_stall"}, 32'(stall_fetch_o), 32'd0);
        end
    endtask

    initial begin
        reset_i = 1'b1;
        exc_valid_i = 1'b0; exc_cause_i = '0; exc_pc_i = '0;
        mret_valid_i = 1'b0;
        irq_ext_i = 1'b0; irq_sw_i = 1'b0; irq_tmr_i = 1'b0;
        mie_bits_i = '0; mstatus_mie_i = 1'b0;
        mtvec_i = '0; mepc_i = '0; current_pc_i = '0;
        pipe_empty_i = 1'b1; redirect_ready_i = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_stall", 32'(stall_fetch_o), 32'd0);
        chk("rst_pulses", 32'({csr_trap_we_o, csr_mret_we_o}), 32'd0);
        chk("rst_rvalid", 32'(redirect_valid_o), 32'd0);
        chk("rst_cause", trap_cause_o, 32'd0);
        chk("rst_pc", trap_pc_o, 32'd0);
        chk("rst_rpc", redirect_pc_o, 32'd0);
        reset_i = 1'b0;
        @(negedge clk);

        // 1) Synchronous exception, direct mtvec
        exc_valid_i = 1'b1; exc_cause_i = 32'd2; exc_pc_i = 32'h100;
        mtvec_i = 32'h2000;
        push(1'b0, 32'd2, 32'h100, 32'h2000);
        fire();
        run_seq("exc", 1, 0);

        // 2) Timer interrupt, vectored mtvec (direct-mode instance too)
        irq_tmr_i = 1'b1; mie_bits_i = 32'h80; mstatus_mie_i = 1'b1;
        mtvec_i = 32'h2001; current_pc_i = 32'h40;
        push(1'b0, 32'h8000_0007, 32'h40, 32'h201C);
        fire();
        irq_tmr_i = 1'b0;
        run_seq("irq_tmr", 1, 0);
        chk("irq_tmr_direct_rpc", rpc_nv, 32'h2000);
        chk("irq_tmr_direct_cause", cause_nv, 32'h8000_0007);

        // 2b) sw beats tmr; direct mtvec ignores cause
        irq_sw_i = 1'b1; irq_tmr_i = 1'b1; mie_bits_i = 32'h88;
        mtvec_i = 32'h4000; current_pc_i = 32'h80;
        push(1'b0, 32'h8000_0003, 32'h80, 32'h4000);
        fire();
        irq_sw_i = 1'b0; irq_tmr_i = 1'b0;
        run_seq("irq_sw", 1, 0);

        // 3) exc + ext + sw together: exception first, then ext irq
        exc_valid_i = 1'b1; exc_cause_i = 32'd4; exc_pc_i = 32'h200;
        irq_ext_i = 1'b1; irq_sw_i = 1'b1; mie_bits_i = 32'h808;
        mtvec_i = 32'h3001; current_pc_i = 32'h204;
        push(1'b0, 32'd4, 32'h200, 32'h3000);
        push(1'b0, 32'h8000_000B, 32'h204, 32'h302C);
        fire();
        run_seq("exc_vs_irq", 1, 0);
        @(negedge clk);
        irq_ext_i = 1'b0; irq_sw_i = 1'b0;
        run_seq("irq_ext_retake", 1, 0);

        // 4) MRET beats a pending irq; fetch withholds ready 3 cycles
        mret_valid_i = 1'b1; mepc_i = 32'h344;
        irq_tmr_i = 1'b1; mie_bits_i = 32'h80; mstatus_mie_i = 1'b1;
        mtvec_i = 32'h2000;
        push(1'b1, 32'd0, 32'h344, 32'h344);
        fire();
        irq_tmr_i = 1'b0;
        mepc_i = 32'h0;
        run_seq("mret", 1, 3);

        // 5) Pipe never empties: COMMIT forced after 15 DRAIN cycles
        pipe_empty_i = 1'b0;
        exc_valid_i = 1'b1; exc_cause_i = 32'd5; exc_pc_i = 32'h500;
        mtvec_i = 32'h2000;
        push(1'b0, 32'd5, 32'h500, 32'h2000);
        fire();
        run_seq("forced", 15, 0);

        // 5b) Reset in the middle of DRAIN
        exc_valid_i = 1'b1; exc_cause_i = 32'd6; exc_pc_i = 32'h600;
        fire();
        @(negedge clk);
        chk("mid_flush", 32'(flush_o), 32'd1);
        reset_i = 1'b1;
        @(negedge clk);
        chk("mid_rst_flush", 32'(flush_o), 32'd0);
        chk("mid_rst_stall", 32'(stall_fetch_o), 32'd0);
        chk("mid_rst_pulses", 32'({csr_trap_we_o, csr_mret_we_o}), 32'd0);
        chk("mid_rst_rvalid", 32'(redirect_valid_o), 32'd0);
        chk("mid_rst_cause", trap_cause_o, 32'd0);
        chk("mid_rst_pc", trap_pc_o, 32'd0);
        chk("mid_rst_rpc", redirect_pc_o, 32'd0);
        reset_i = 1'b0;
        pipe_empty_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_pulses", 32'({csr_trap_we_o, csr_mret_we_o}), 32'd0);
            chk("post_rst_rvalid", 32'(redirect_valid_o), 32'd0);
        end

        // 6) Masked interrupts never start a sequence
        irq_tmr_i = 1'b1; mie_bits_i = 32'h80; mstatus_mie_i = 1'b0;
        check_quiet("masked_mstatus", 3);
        mstatus_mie_i = 1'b1; mie_bits_i = 32'h08;
        check_quiet("masked_mie", 3);
        irq_tmr_i = 1'b0;

        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
